vga_timing_core: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_timing_core.sv | 151 +++++++++++++++
 tb/tb_vga_timing_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and helpers: default 640x480@60 timing,
// line/frame totals, active-window start and counter width.
package vga_timing_pkg;

    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_V_FRONT = 10;

    // Per-pixel video flags that travel down the delay line to meet host colour.
    typedef struct packed {
        logic hs;
        logic vs;
        logic vld;
    } vidFlags_t;

    function automatic int timingTotal(input int sync, input int back,
                                       input int act, input int front);
        return sync + back + act + front;
    endfunction

    function automatic int actStart(input int sync, input int back);
        return sync + back;
    endfunction

    function automatic int cntWidth(input int total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width x depth shift register with asynchronous clear; aligns the
// sync/blank flags with colour returning from the host.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= iData;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign oData = taps[DEPTH-1];

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA raster engine: counters, coordinate/tick stream for the
// renderer, and latency-aligned sync/blank/RGB towards the ADV7123 DAC.
module vga_timing_core
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int H_ACT     = DEF_H_ACT,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int PIPE_LAT  = 1,
    parameter int COLOR_W   = 10,
    parameter int COORD_W   = 10,
    parameter int FRAME_DIV = 6
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic [COORD_W-1:0] oCoord_X,
    output logic [COORD_W-1:0] oCoord_Y,
    output logic               oCoord_Valid,
    output logic               oLine_Start,
    output logic               oFrame_Tick,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);

    localparam int H_TOTAL = timingTotal(H_SYNC, H_BACK, H_ACT, H_FRONT);
    localparam int V_TOTAL = timingTotal(V_SYNC, V_BACK, V_ACT, V_FRONT);
    localparam int HW      = cntWidth(H_TOTAL);
    localparam int VW      = cntWidth(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_START = HW'(actStart(H_SYNC, H_BACK));
    localparam logic [HW-1:0] H_END   = HW'(actStart(H_SYNC, H_BACK) + H_ACT - 1);
    localparam logic [HW-1:0] H_SEND  = HW'(H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_START = VW'(actStart(V_SYNC, V_BACK));
    localparam logic [VW-1:0] V_END   = VW'(actStart(V_SYNC, V_BACK) + V_ACT - 1);
    localparam logic [VW-1:0] V_SEND  = VW'(V_SYNC);

    localparam logic [7:0] FDIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic       HS_ON     = (HS_POL != 0);
    localparam logic       VS_ON     = (VS_POL != 0);

    // Stage p0: raster counters and the flags decoded from them
    logic [HW-1:0] hCnt_p0;
    logic [VW-1:0] vCnt_p0;
    logic          hAct_p0;
    logic          vAct_p0;
    logic          frameEnd_p0;
    vidFlags_t     flags_p0;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCnt_p0 <= '0;
            vCnt_p0 <= '0;
        end else if (hCnt_p0 == H_LAST) begin
            hCnt_p0 <= '0;
            vCnt_p0 <= (vCnt_p0 == V_LAST) ? '0 : vCnt_p0 + VW'(1);
        end else begin
            hCnt_p0 <= hCnt_p0 + HW'(1);
        end
    end

    assign hAct_p0      = (hCnt_p0 >= H_START) && (hCnt_p0 <= H_END);
    assign vAct_p0      = (vCnt_p0 >= V_START) && (vCnt_p0 <= V_END);
    assign frameEnd_p0  = (hCnt_p0 == H_END) && (vCnt_p0 == V_END);
    assign flags_p0.hs  = (hCnt_p0 < H_SEND);
    assign flags_p0.vs  = (vCnt_p0 < V_SEND);
    assign flags_p0.vld = hAct_p0 && vAct_p0;

    // Stage p1: renderer-facing coordinate stream and the divided frame tick
    logic [7:0] frameCnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCoord_X     <= '0;
            oCoord_Y     <= '0;
            oCoord_Valid <= 1'b0;
            oLine_Start  <= 1'b0;
            oFrame_Tick  <= 1'b0;
            frameCnt     <= '0;
        end else begin
            oCoord_Valid <= flags_p0.vld;
            oLine_Start  <= flags_p0.vld && (hCnt_p0 == H_START);
            if (flags_p0.vld) begin
                oCoord_X <= COORD_W'(hCnt_p0 - H_START);
                oCoord_Y <= COORD_W'(vCnt_p0 - V_START);
            end
            oFrame_Tick <= 1'b0;
            if (frameEnd_p0) begin
                if (frameCnt == FDIV_LAST) begin
                    frameCnt    <= '0;
                    oFrame_Tick <= 1'b1;
                end else begin
                    frameCnt <= frameCnt + 8'd1;
                end
            end
        end
    end

    // One extra tap covers the coordinate register, so flags land with the host colour
    vidFlags_t flags_p1;

    vga_delay_line #(
        .WIDTH($bits(vidFlags_t)),
        .DEPTH(PIPE_LAT + 1)
    ) uFlagDelay (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .iData (flags_p0),
        .oData (flags_p1)
    );

    // Stage p2: DAC outputs, colour masked outside the active window
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R      <= '0;
            oVGA_G      <= '0;
            oVGA_B      <= '0;
            oVGA_BLANK  <= 1'b0;
            oVGA_H_SYNC <= ~HS_ON;
            oVGA_V_SYNC <= ~VS_ON;
        end else begin
            oVGA_R      <= flags_p1.vld ? iRed   : '0;
            oVGA_G      <= flags_p1.vld ? iGreen : '0;
            oVGA_B      <= flags_p1.vld ? iBlue  : '0;
            oVGA_BLANK  <= flags_p1.vld;
            oVGA_H_SYNC <= flags_p1.hs ? HS_ON : ~HS_ON;
            oVGA_V_SYNC <= flags_p1.vs ? VS_ON : ~VS_ON;
        end
    end

    assign oVGA_SYNC  = 1'b0;
    assign oVGA_CLOCK = iCLK;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core on a tiny 16x9 raster with positive syncs,
// PIPE_LAT=3 host echo of the coordinates and a divide-by-2 frame tick.
module tb_vga_timing_core;

    localparam int HS = 8, HB = 2, HA = 4, HF = 2;
    localparam int VS = 4, VB = 1, VA = 3, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 16
    localparam int VT = VS + VB + VA + VF;   // 9
    localparam int FT = HT * VT;             // 144
    localparam int LAT  = 3;
    localparam int L    = LAT + 2;
    localparam int FDIV = 2;
    localparam int CW   = 10;

    logic          clk  = 1'b0;
    logic          rstN = 1'b0;
    logic [CW-1:0] red, green, blue;
    logic [CW-1:0] coordX, coordY, vgaR, vgaG, vgaB;
    logic          coordValid, lineStart, frameTick;
    logic          vgaHs, vgaVs, vgaBlank, vgaSync, vgaClock;

    always #5 clk = ~clk;

    vga_timing_core #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
        .HS_POL(1), .VS_POL(1), .PIPE_LAT(LAT),
        .COLOR_W(CW), .COORD_W(CW), .FRAME_DIV(FDIV)
    ) dut (
        .iCLK(clk), .iRST_N(rstN),
        .iRed(red), .iGreen(green), .iBlue(blue),
        .oCoord_X(coordX), .oCoord_Y(coordY),
        .oCoord_Valid(coordValid), .oLine_Start(lineStart), .oFrame_Tick(frameTick),
        .oVGA_R(vgaR), .oVGA_G(vgaG), .oVGA_B(vgaB),
        .oVGA_H_SYNC(vgaHs), .oVGA_V_SYNC(vgaVs), .oVGA_BLANK(vgaBlank),
        .oVGA_SYNC(vgaSync), .oVGA_CLOCK(vgaClock)
    );

    // Host renderer: echoes X on red and Y on green, LAT cycles after the request
    logic [CW-1:0] xDly [LAT];
    logic [CW-1:0] yDly [LAT];
    always @(posedge clk) begin
        xDly[0] <= coordX;
        yDly[0] <= coordY;
        for (int i = 1; i < LAT; i++) begin
            xDly[i] <= xDly[i-1];
            yDly[i] <= yDly[i-1];
        end
    end
    assign red   = xDly[LAT-1];
    assign green = yDly[LAT-1];

    int nChecks = 0;
    int nErrors = 0;
    int m;            // rising edges since reset release == raster state index
    int expX, expY;
    int prevBlank, prevR, lastTick, firstHs, firstValid, phase;
    int validCnt, hsCnt, vsCnt;

    task automatic check(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs != exp) begin
            nErrors++;
            $display("FAIL %s at m=%0d: got %0d, expected %0d", tag, m, obs, exp);
        end
    endtask

    function automatic int hOf(input int s);
        return s % HT;
    endfunction

    function automatic int vOf(input int s);
        return (s / HT) % VT;
    endfunction

    function automatic bit actOf(input int s);
        int h = hOf(s);
        int v = vOf(s);
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    task automatic checkReset(input string tag);
        check({tag, ".x"}, coordX, 0);
        check({tag, ".y"}, coordY, 0);
        check({tag, ".valid"}, coordValid, 0);
        check({tag, ".lineStart"}, lineStart, 0);
        check({tag, ".tick"}, frameTick, 0);
        check({tag, ".r"}, vgaR, 0);
        check({tag, ".g"}, vgaG, 0);
        check({tag, ".b"}, vgaB, 0);
        check({tag, ".blank"}, vgaBlank, 0);
        check({tag, ".hs"}, vgaHs, 0);
        check({tag, ".vs"}, vgaVs, 0);
    endtask

    task automatic checkCycle();
        int  s1 = m - 1;
        int  sD = m - L;
        int  h1 = hOf(s1);
        int  v1 = vOf(s1);
        bit  a1 = actOf(s1);
        bit  aD;
        int  tickExp;
        if (a1) begin
            expX = h1 - (HS + HB);
            expY = v1 - (VS + VB);
        end
        tickExp = ((h1 == HS + HB + HA - 1) && (v1 == VS + VB + VA - 1) &&
                   ((s1 / FT) % FDIV == FDIV - 1)) ? 1 : 0;
        check("coordX", coordX, expX);
        check("coordY", coordY, expY);
        check("coordValid", coordValid, a1 ? 1 : 0);
        check("lineStart", lineStart, (a1 && h1 == HS + HB) ? 1 : 0);
        check("frameTick", frameTick, tickExp);
        check("vgaSync", vgaSync, 0);
        check("vgaClock", vgaClock, clk);
        if (sD < 0) begin
            check("hsPre", vgaHs, 0);
            check("vsPre", vgaVs, 0);
            check("blankPre", vgaBlank, 0);
            check("rgbPre", {vgaR, vgaG, vgaB}, 0);
        end else begin
            aD = actOf(sD);
            check("hsync", vgaHs, (hOf(sD) < HS) ? 1 : 0);
            check("vsync", vgaVs, (vOf(sD) < VS) ? 1 : 0);
            check("blank", vgaBlank, aD ? 1 : 0);
            check("red", vgaR, aD ? hOf(sD) - (HS + HB) : 0);
            check("green", vgaG, aD ? vOf(sD) - (VS + VB) : 0);
            check("blue", vgaB, aD ? 1023 : 0);
        end
        if (vgaBlank && prevBlank == 0) check("blankRiseX", vgaR, 0);
        if (!vgaBlank && prevBlank == 1) check("blankFallX", prevR, HA - 1);
        prevBlank = vgaBlank;
        prevR     = vgaR;
        if (frameTick) begin
            if (lastTick >= 0) check("tickSpacing", m - lastTick, FDIV * FT);
            lastTick = m;
        end
        if (vgaHs && firstHs < 0) firstHs = m;
        if (coordValid && firstValid < 0) begin
            firstValid = m;
            check("firstValidX", coordX, 0);
            check("firstValidY", coordY, 0);
        end
        if (phase == 1) begin
            if (m >= 1 && m < 1 + FT && coordValid) validCnt++;
            if (m >= L && m < L + HT && vgaHs) hsCnt++;
            if (m >= L && m < L + FT && vgaVs) vsCnt++;
        end
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            m++;
            @(negedge clk);
            checkCycle();
        end
    endtask

    task automatic restartModel(input int ph);
        m = 0; expX = 0; expY = 0; prevBlank = 0; prevR = 0;
        lastTick = -1; firstHs = -1; firstValid = -1; phase = ph;
    endtask

    initial begin
        blue = '1;
        validCnt = 0; hsCnt = 0; vsCnt = 0;
        restartModel(1);
        repeat (3) @(negedge clk);
        checkReset("rstInit");
        rstN = 1'b1;
        runCycles(2 * FT + 108);   // stops mid-line inside the active window
        check("validPerFrame", validCnt, HA * VA);
        check("hsWidth", hsCnt, HS);
        check("vsWidth", vsCnt, VS * HT);
        check("firstHs1", firstHs, L);
        check("firstValid1", firstValid, 1 + (VS + VB) * HT + HS + HB);

        #2 rstN = 1'b0;
        #1 checkReset("rstMid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset("rstHeld");
        rstN = 1'b1;
        restartModel(2);
        runCycles(4 * FT + 24);
        check("firstHs2", firstHs, L);
        check("firstValid2", firstValid, 1 + (VS + VB) * HT + HS + HB);
        check("lastTick2", lastTick, 1 + FT + (VS + VB + VA - 1) * HT + HS + HB + HA - 1 + 2 * FT);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
